// File: rtl/fsm_tx.sv
// Self-starting 8N1 UART transmitter: after each reset release it sends one
// frame of datain on x, raises Done, and then holds the line idle until the next reset.
module fsm_tx #(
   parameter int TICK_DIV = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] datain,
   output logic       x,
   output logic       tick,
   output logic       Done
);

   localparam int             CW      = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          tick_q;
   logic          tx_q, tx_d;
   logic          done_q, done_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;

   // The baud strobe is registered, so it rises one clk after the count hits its maximum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
         tick_q <= (cnt_q == CNT_MAX);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tick_q) begin
         case (state_q)
            IDLE:    state_d = START;
            START:   state_d = DATA;
            DATA:    if (idx_q == 3'd7) state_d = STOP;
            STOP:    state_d = DONE;
            default: state_d = DONE;
         endcase
      end
   end

   // datain is captured only when leaving IDLE; the frame then runs from shift_q.
   always_comb begin
      tx_d    = tx_q;
      done_d  = done_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      if (tick_q) begin
         case (state_q)
            IDLE: begin
               shift_d = datain;
               tx_d    = 1'b0;
            end
            START: begin
               tx_d  = shift_q[0];
               idx_d = '0;
            end
            DATA: begin
               if (idx_q == 3'd7) begin
                  tx_d = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = shift_q[idx_q + 3'd1];
               end
            end
            STOP: begin
               tx_d   = 1'b1;
               done_d = 1'b1;
            end
            default: begin
               tx_d   = 1'b1;
               done_d = 1'b1;
            end
         endcase
      end
   end

   assign x    = tx_q;
   assign tick = tick_q;
   assign Done = done_q;

endmodule

// File: tb/tb_fsm_tx.sv
// Directed bench for fsm_tx: reset values, tick spacing, two frames, data
// stability, post-Done idle and mid-frame abort.
module tb_fsm_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] datain = 8'h00;
   logic       x, tick, Done;
   int         n_vec = 0;
   int         n_err = 0;

   fsm_tx #(.TICK_DIV(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .datain (datain),
      .x      (x),
      .tick   (tick),
      .Done   (Done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Counts falling edges until tick is seen high; the sample is then pre-update.
   task automatic wait_tick(output int c);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!tick && c < 64);
      if (!tick) chk("tick_timeout", 32'd0, 32'd1);
   endtask

   task automatic next_tick(input string tag);
      int c;
      @(negedge clk);
      chk({tag, "_tick_width"}, {31'd0, tick}, 32'd0);
      wait_tick(c);
      chk({tag, "_tick_gap"}, c + 1, 32'd16);
   endtask

   task automatic run_frame(input string tag, input logic [7:0] d, input bit poke);
      logic [10:0] seq;
      int c;
      seq = {1'b1, d, 1'b0, 1'b1};
      wait_tick(c);
      chk({tag, "_first_tick"}, c, 32'd16);
      for (int k = 0; k < 11; k++) begin
         if (k > 0) next_tick(tag);
         chk($sformatf("%s_x%0d", tag, k), {31'd0, x}, {31'd0, seq[k]});
         chk($sformatf("%s_done%0d", tag, k), {31'd0, Done}, 32'd0);
         if (poke && k == 4) datain = 8'h00;
      end
      next_tick(tag);
      chk({tag, "_done_end"}, {31'd0, Done}, 32'd1);
      chk({tag, "_x_end"}, {31'd0, x}, 32'd1);
   endtask

   initial begin
      int c;
      datain = 8'b10110011;
      reset  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_x", {31'd0, x}, 32'd1);
      chk("rst_done", {31'd0, Done}, 32'd0);
      chk("rst_tick", {31'd0, tick}, 32'd0);

      reset = 1'b1;
      run_frame("f1", 8'b10110011, 1'b0);

      #40;
      datain = 8'b11001100;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("f2_rst_done", {31'd0, Done}, 32'd0);
      chk("f2_rst_x", {31'd0, x}, 32'd1);
      chk("f2_rst_tick", {31'd0, tick}, 32'd0);
      @(negedge clk) reset = 1'b1;
      run_frame("f2", 8'b11001100, 1'b1);

      for (int i = 0; i < 20; i++) begin
         next_tick("idle");
         chk($sformatf("idle_x%0d", i), {31'd0, x}, 32'd1);
         chk($sformatf("idle_done%0d", i), {31'd0, Done}, 32'd1);
      end

      // Abort a frame while a zero data bit is on the line.
      @(negedge clk) reset = 1'b0;
      datain = 8'h00;
      @(negedge clk) reset = 1'b1;
      wait_tick(c);
      for (int k = 1; k < 5; k++) next_tick("ab");
      chk("ab_x_low", {31'd0, x}, 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("ab_x", {31'd0, x}, 32'd1);
      chk("ab_done", {31'd0, Done}, 32'd0);
      chk("ab_tick", {31'd0, tick}, 32'd0);
      datain = 8'hA5;
      @(negedge clk) reset = 1'b1;
      run_frame("f4", 8'hA5, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
